key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter N_KEYS, default 4: number of push-button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: cycles a level must hold stable (20 ms at 50 MHz).
REQ-003 SHALL have parameter REPEAT_DELAY, default 25000000: cycles from press_pulse to first repeat_pulse.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 5000000: cycles between later repeat_pulses.
REQ-005 SHALL have parameter REPEAT_EN, default 1: 0 disables all repeat_pulse output.
REQ-006 SHALL have port CLOCK_50, input, 1 bit: the single clock.
REQ-007 SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port KEY, input, N_KEYS bits: raw buttons, active-low, asynchronous to CLOCK_50.
REQ-009 SHALL have port key_level, output, N_KEYS bits: debounced held state, 1 = pressed.
REQ-010 SHALL have port press_pulse, output, N_KEYS bits: one-cycle strobe on each debounced press.
REQ-011 SHALL have port release_pulse, output, N_KEYS bits: one-cycle strobe on each debounced release.
REQ-012 SHALL have port repeat_pulse, output, N_KEYS bits: one-cycle auto-repeat strobe while a key is held.

Function
REQ-013 SHALL pass each KEY bit through a 2-flop synchronizer; the synchronized signal is ks (active-low).
REQ-014 SHALL run an independent FSM per channel with states IDLE, DEB_PRESS, HELD, REPEAT and DEB_REL, plus one counter sized for max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).
REQ-015 IDLE: ks=0 -> DEB_PRESS with counter=0.
REQ-016 DEB_PRESS: ks=1 -> IDLE with no output (bounce rejected); otherwise count up; at count DEBOUNCE_CYCLES-1 -> HELD, press_pulse=1 for one cycle, key_level=1, counter cleared.
REQ-017 HELD: ks=1 -> DEB_REL with counter=0; otherwise count up; at REPEAT_DELAY-1 with REPEAT_EN=1 -> REPEAT, repeat_pulse=1 for one cycle, counter cleared.
REQ-018 REPEAT: ks=1 -> DEB_REL; otherwise repeat_pulse=1 for one cycle every REPEAT_PERIOD cycles.
REQ-019 DEB_REL: ks=0 -> HELD with counter cleared (repeat delay restarts, no press_pulse); ks=1 for DEBOUNCE_CYCLES cycles -> IDLE, release_pulse=1 for one cycle, key_level=0.
REQ-020 With REPEAT_EN=0 the HELD counter SHALL saturate and never wrap.
REQ-021 All outputs SHALL be registered; press, repeat and release pulses SHALL be mutually exclusive per channel within any cycle.
REQ-022 Latency SHALL be fixed: press_pulse is high at clock edge 2+DEBOUNCE_CYCLES, counting from edge 0 (the first edge sampling KEY low, with KEY held low throughout).
REQ-023 Channels SHALL be fully independent; simultaneous presses on several keys SHALL each produce their own pulses in the same cycle.

Reset
REQ-024 RESET_N=0 SHALL asynchronously force synchronizer flops to 1, every FSM to IDLE, all counters to 0 and all outputs to 0.
REQ-025 Reset asserted while a key is held SHALL emit no release_pulse; after deassertion, the held key SHALL re-debounce and produce press_pulse.

Structure
REQ-026 A shared package SHALL hold the channel state enum and the default timing constants (50 MHz derived).
REQ-027 The natural sub-module SHALL be key_channel (synchronizer + FSM + counter), instantiated N_KEYS times by a generate loop in key_conditioner.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_KEYS=4)
REQ-028 KEY[0] low from edge 0 and held -> press_pulse[0] at edge 6; key_level[0]=1 from edge 6.
REQ-029 KEY[1] low for 3 cycles, then high -> no pulses on any output; key_level[1] stays 0.
REQ-030 KEY[2] held 40 cycles -> one press_pulse, then repeat_pulse 10 cycles later and every 3 cycles after; release_pulse exactly 2+4 cycles after KEY rises.
REQ-031 With KEY[3] held, glitch it high for 2 cycles -> no release_pulse; key_level stays 1; repeat delay restarts.
REQ-032 KEY[0] and KEY[3] fall on the same edge -> press_pulse=4'b1001 in one cycle.
REQ-033 RESET_N low while KEY[0] is held -> all outputs 0 immediately; after release of reset, press_pulse[0] arrives 6 edges later.

Source files
------------

// File: rtl/key_conditioner_pkg.sv
// Shared types and default timing for the push-button conditioner.
// The defaults assume a 50 MHz clock.
package key_conditioner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DEB_PRESS = 3'd1,
    ST_HELD      = 3'd2,
    ST_REPEAT    = 3'd3,
    ST_DEB_REL   = 3'd4
  } key_state_e;

  localparam int CLK_HZ              = 32'sd50_000_000;
  localparam int DEF_N_KEYS          = 32'sd4;
  localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 32'sd50;  // 20 ms
  localparam int DEF_REPEAT_DELAY    = CLK_HZ / 32'sd2;   // 500 ms
  localparam int DEF_REPEAT_PERIOD   = CLK_HZ / 32'sd10;  // 100 ms
  localparam int DEF_REPEAT_EN       = 32'sd1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

  // Width able to hold every count value up to the largest timing constant.
  function automatic int cnt_width(input int a, input int b, input int c);
    int w;
    w = $clog2(max3(a, b, c) + 32'sd1);
    if (w < 32'sd1) begin
      w = 32'sd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One push-button channel: 2-flop synchronizer, debounce/repeat FSM and
// its shared counter. All outputs are registered.
module key_channel
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int REPEAT_EN       = DEF_REPEAT_EN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 32'sd1);
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 32'sd1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 32'sd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};
  localparam bit            RPT_ON   = (REPEAT_EN != 32'sd0);

  logic       sync1_r;
  logic       ks_r;
  key_state_e state_r;
  logic [CW-1:0] cnt_r;

  // Synchronize the raw active-low key into the clock domain (idle = 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      ks_r    <= 1'b1;
    end else begin
      sync1_r <= key_n;
      ks_r    <= sync1_r;
    end
  end

  // Channel FSM with registered level and pulse outputs; pulses are only
  // raised in distinct branches, so at most one fires per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= CNT_ZERO;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= CNT_ZERO;
          if (!ks_r) begin
            state_r <= ST_DEB_PRESS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DEB_PRESS: begin
          if (ks_r) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == DEB_LAST) begin
            state_r     <= ST_HELD;
            cnt_r       <= CNT_ZERO;
            press_pulse <= 1'b1;
            key_level   <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_HELD: begin
          if (ks_r) begin
            state_r <= ST_DEB_REL;
            cnt_r   <= CNT_ZERO;
          end else if (RPT_ON && (cnt_r == DLY_LAST)) begin
            state_r      <= ST_REPEAT;
            cnt_r        <= CNT_ZERO;
            repeat_pulse <= 1'b1;
          end else if (cnt_r != CNT_SAT) begin
            cnt_r <= cnt_r + CNT_ONE;
          end else begin
            cnt_r <= cnt_r;  // hold at saturation when repeat is disabled
          end
        end
        ST_REPEAT: begin
          if (ks_r) begin
            state_r <= ST_DEB_REL;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == PER_LAST) begin
            cnt_r        <= CNT_ZERO;
            repeat_pulse <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DEB_REL: begin
          if (!ks_r) begin
            state_r <= ST_HELD;  // release bounce: restart the repeat delay
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == DEB_LAST) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            release_pulse <= 1'b1;
            key_level     <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= CNT_ZERO;
          key_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Debounced push-button conditioner: N_KEYS independent channels producing
// held level plus press, release and auto-repeat strobes.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int N_KEYS          = DEF_N_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int REPEAT_EN       = DEF_REPEAT_EN
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] repeat_pulse
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_EN)
    ) u_chan (
      .clk           (CLOCK_50),
      .rst_n         (RESET_N),
      .key_n         (KEY[i]),
      .key_level     (key_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed vectors and sequences
// plus random key activity against an event-level reference model.
module tb_key_conditioner;

  localparam int D = 4;
  localparam int R = 10;
  localparam int P = 3;

  logic       CLOCK_50;
  logic       RESET_N;
  logic [3:0] KEY;
  logic [3:0] key_level, press_pulse, release_pulse, repeat_pulse;
  logic [3:0] nr_level, nr_press, nr_release, nr_repeat;

  key_conditioner #(.N_KEYS(4), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(R),
                    .REPEAT_PERIOD(P), .REPEAT_EN(1)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .KEY(KEY),
    .key_level(key_level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .repeat_pulse(repeat_pulse));

  key_conditioner #(.N_KEYS(4), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(R),
                    .REPEAT_PERIOD(P), .REPEAT_EN(0)) dut_nr (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .KEY(KEY),
    .key_level(nr_level), .press_pulse(nr_press),
    .release_pulse(nr_release), .repeat_pulse(nr_repeat));

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: synchronizer delay plus run lengths of the observed key.
  logic [3:0] m_s1, m_s2, m_level, e_press, e_rel, e_rep;
  int low_run[4], high_run[4], age[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got 0x%0h want 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 4'hF; m_s2 = 4'hF; m_level = 4'h0;
    e_press = 4'h0; e_rel = 4'h0; e_rep = 4'h0;
    for (int c = 0; c < 4; c++) begin
      low_run[c] = 0; high_run[c] = 0; age[c] = 0;
    end
  endtask

  task automatic model_edge(input logic [3:0] k);
    logic ks;
    e_press = 4'h0; e_rel = 4'h0; e_rep = 4'h0;
    for (int c = 0; c < 4; c++) begin
      ks = m_s2[c];
      if (!ks) begin low_run[c]++; high_run[c] = 0; end
      else begin high_run[c]++; low_run[c] = 0; end
      if (!m_level[c]) begin
        if (!ks && low_run[c] == D + 1) begin
          e_press[c] = 1'b1; m_level[c] = 1'b1; age[c] = 0;
        end
      end else if (ks) begin
        if (high_run[c] == D + 1) begin
          e_rel[c] = 1'b1; m_level[c] = 1'b0;
        end
      end else begin
        if (low_run[c] == 1) age[c] = 0;
        else age[c]++;
        if (age[c] >= R && ((age[c] - R) % P) == 0) e_rep[c] = 1'b1;
      end
    end
    m_s2 = m_s1;
    m_s1 = k;
  endtask

  task automatic check_outputs();
    check("level", {28'h0, key_level}, {28'h0, m_level});
    check("press", {28'h0, press_pulse}, {28'h0, e_press});
    check("release", {28'h0, release_pulse}, {28'h0, e_rel});
    check("repeat", {28'h0, repeat_pulse}, {28'h0, e_rep});
    check("nr_level", {28'h0, nr_level}, {28'h0, m_level});
    check("nr_press", {28'h0, nr_press}, {28'h0, e_press});
    check("nr_release", {28'h0, nr_release}, {28'h0, e_rel});
    check("nr_repeat", {28'h0, nr_repeat}, 32'h0);
  endtask

  // One clock: drive KEY at the falling edge, update model at the rising edge.
  task automatic step(input logic [3:0] k);
    KEY = k;
    @(posedge CLOCK_50);
    if (!RESET_N) model_reset();
    else model_edge(k);
    @(negedge CLOCK_50);
    check_outputs();
  endtask

  typedef struct {
    logic [3:0] key;
    logic [3:0] press;
    logic [3:0] level;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int p_idx, p_cnt, r_first, r_last, r_cnt, rel_idx, rel_cnt, bad_lvl, any_cnt;
    logic [3:0] k;

    for (int i = 0; i < 10; i++) begin
      tbl[i].key   = 4'b0110;
      tbl[i].press = (i == 6) ? 4'b1001 : 4'b0000;
      tbl[i].level = (i >= 6) ? 4'b1001 : 4'b0000;
    end

    RESET_N = 1'b0;
    KEY = 4'hF;
    model_reset();
    @(negedge CLOCK_50);
    step(4'hF);
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) step(4'hF);

    // KEY[0] and KEY[3] fall together: joint press on edge 6
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].key);
      check("tbl_press", {28'h0, press_pulse}, {28'h0, tbl[i].press});
      check("tbl_level", {28'h0, key_level}, {28'h0, tbl[i].level});
    end
    for (int i = 0; i < 12; i++) step(4'hF);

    // Short bounce on KEY[1] is rejected
    any_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      step(i < 3 ? 4'b1101 : 4'b1111);
      if ((press_pulse | release_pulse | repeat_pulse) != 4'h0) any_cnt++;
      if (key_level[1]) any_cnt++;
    end
    check("bounce_activity", any_cnt, 0);

    // KEY[2] held 40 cycles: press, repeats, release timing
    p_idx = -1; p_cnt = 0; r_first = -1; r_last = -1; r_cnt = 0; rel_idx = -1;
    for (int i = 0; i < 50; i++) begin
      step(i < 40 ? 4'b1011 : 4'b1111);
      if (press_pulse[2]) begin if (p_idx < 0) p_idx = i; p_cnt++; end
      if (repeat_pulse[2]) begin if (r_first < 0) r_first = i; r_last = i; r_cnt++; end
      if (release_pulse[2]) rel_idx = i;
    end
    check("hold_press_at", p_idx, 6);
    check("hold_press_cnt", p_cnt, 1);
    check("hold_rep_first", r_first, 16);
    check("hold_rep_last", r_last, 40);
    check("hold_rep_cnt", r_cnt, 9);
    check("hold_release_at", rel_idx, 46);

    // KEY[3] held with a 2-cycle release glitch
    rel_cnt = 0; bad_lvl = 0; r_first = -1;
    for (int i = 0; i < 54; i++) begin
      k = (i < 20 || (i >= 22 && i < 42)) ? 4'b0111 : 4'b1111;
      step(k);
      if (i < 42 && release_pulse[3]) rel_cnt++;
      if (i >= 6 && i < 42 && !key_level[3]) bad_lvl++;
      if (i >= 22 && repeat_pulse[3] && r_first < 0) r_first = i;
    end
    check("glitch_release", rel_cnt, 0);
    check("glitch_level", bad_lvl, 0);
    check("glitch_rep_restart", r_first, 34);

    // Reset while KEY[0] is held
    for (int i = 0; i < 10; i++) step(4'b1110);
    RESET_N = 1'b0;
    #1;
    check("rst_level", {28'h0, key_level}, 32'h0);
    check("rst_pulses", {20'h0, press_pulse, release_pulse, repeat_pulse}, 32'h0);
    model_reset();
    @(negedge CLOCK_50);
    step(4'b1110);
    step(4'b1110);
    RESET_N = 1'b1;
    p_idx = -1; rel_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(4'b1110);
      if (press_pulse[0] && p_idx < 0) p_idx = i;
      if (release_pulse != 4'h0) rel_cnt++;
    end
    check("rst_repress_at", p_idx, 6);
    check("rst_no_release", rel_cnt, 0);
    for (int i = 0; i < 10; i++) step(4'hF);

    // Random activity: fast bouncing, then long holds, rare resets
    k = 4'hF;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range((i < 400) ? 3 : 23, 0) == 0) k[c] = ~k[c];
      end
      if ($urandom_range(299, 0) == 0) RESET_N = 1'b0;
      else RESET_N = 1'b1;
      step(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
